// File: rtl/bsg_activation_rr_sched.sv
// Round-robin scheduler sharing one bsg_activation unit (single op in flight) among
// num_req_p requesters; the result is returned only to the requester that owns the op.
module bsg_activation_rr_sched #(
  parameter int unsigned num_req_p   = 4,
  parameter int unsigned ang_width_p = 21,
  parameter int unsigned ans_width_p = 32
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*ang_width_p-1:0] req_ang_i,
  input  logic [num_req_p-1:0]             req_tanh_sel_i,
  output logic [num_req_p-1:0]             req_ready_o,
  output logic [num_req_p-1:0]             resp_v_o,
  output logic [ans_width_p-1:0]           resp_data_o,
  input  logic [num_req_p-1:0]             resp_yumi_i,
  output logic                             act_v_o,
  input  logic                             act_ready_i,
  output logic [ang_width_p-1:0]           act_ang_o,
  output logic                             act_tanh_sel_o,
  input  logic                             act_v_i,
  input  logic [ans_width_p-1:0]           act_data_i,
  output logic                             act_yumi_o,
  output logic                             busy_o
);

  localparam int unsigned lg_req_lp = $clog2(num_req_p);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                 state_r;
  logic [lg_req_lp-1:0]   last_grant_r;
  logic [lg_req_lp-1:0]   owner_r;
  logic [ang_width_p-1:0] ang_r;
  logic                   tanh_r;

  logic [lg_req_lp-1:0]   winner;
  logic                   found;
  logic                   owner_yumi;
  int unsigned            idx;
  logic [ang_width_p-1:0] lane_ang [num_req_p];

  // Unpack the flat angle bus into per-lane words
  always_comb begin
    for (int k = 0; k < num_req_p; k++) begin
      lane_ang[k] = req_ang_i[k*ang_width_p +: ang_width_p];
    end
  end

  // Round-robin search starting one past the last grant, wrapping around
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= num_req_p; i++) begin
      idx = (32'(last_grant_r) + i) % num_req_p;
      if (!found && req_v_i[lg_req_lp'(idx)]) begin
        found  = 1'b1;
        winner = lg_req_lp'(idx);
      end
    end
  end

  assign owner_yumi = resp_yumi_i[owner_r];

  // Grant is combinational so the winner transfers in the same IDLE cycle
  always_comb begin
    req_ready_o = '0;
    resp_v_o    = '0;
    if ((state_r == IDLE) && !reset_i && found) begin
      req_ready_o[winner] = 1'b1;
    end
    if (state_r == RESP) begin
      resp_v_o[owner_r] = 1'b1;
    end
  end

  assign resp_data_o    = (state_r == RESP) ? act_data_i : '0;
  assign act_v_o        = (state_r == ISSUE);
  assign act_yumi_o     = (state_r == RESP) && owner_yumi;
  assign act_ang_o      = ang_r;
  assign act_tanh_sel_o = tanh_r;
  assign busy_o         = (state_r != IDLE);

  // Operand and owner are frozen at accept; later requester changes are ignored
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= IDLE;
      last_grant_r <= lg_req_lp'(num_req_p - 1);
      owner_r      <= '0;
      ang_r        <= '0;
      tanh_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found) begin
            owner_r      <= winner;
            last_grant_r <= winner;
            ang_r        <= lane_ang[winner];
            tanh_r       <= req_tanh_sel_i[winner];
            state_r      <= ISSUE;
          end
        end
        ISSUE: if (act_ready_i) state_r <= WAIT;
        WAIT:  if (act_v_i)     state_r <= RESP;
        RESP:  if (owner_yumi)  state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_activation_rr_sched.sv
// Bench for bsg_activation_rr_sched: random requesters and a stand-in activation unit,
// transaction-level round-robin model feeding a response scoreboard.
module tb_bsg_activation_rr_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N-1:0]    req_v_i;
  logic [N*AW-1:0] req_ang_i;
  logic [N-1:0]    req_tanh_sel_i;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    resp_v_o;
  logic [DW-1:0]   resp_data_o;
  logic [N-1:0]    resp_yumi_i;
  logic            act_v_o;
  logic            act_ready_i;
  logic [AW-1:0]   act_ang_o;
  logic            act_tanh_sel_o;
  logic            act_v_i;
  logic [DW-1:0]   act_data_i;
  logic            act_yumi_o;
  logic            busy_o;

  bsg_activation_rr_sched #(.num_req_p(N), .ang_width_p(AW), .ans_width_p(DW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_ang_i(req_ang_i), .req_tanh_sel_i(req_tanh_sel_i),
    .req_ready_o(req_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_yumi_i(resp_yumi_i), .act_v_o(act_v_o), .act_ready_i(act_ready_i),
    .act_ang_o(act_ang_o), .act_tanh_sel_o(act_tanh_sel_o), .act_v_i(act_v_i),
    .act_data_i(act_data_i), .act_yumi_o(act_yumi_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [DW-1:0] data;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // requester lanes, mode: 0 random, 1 directed, 2 all lanes always valid
  logic [N-1:0]  lane_v;
  logic [AW-1:0] lane_ang [N];
  logic [N-1:0]  lane_tanh;
  logic [N-1:0]  accepted;
  int            mode;
  logic [N-1:0]  yumi_force;

  // reference model of the scheduler
  exp_t          exp_q [$];
  bit            m_busy;
  int            m_last;
  int            busy_cycles;
  int            done_cnt = 0;
  int            done_seen;
  int            g_cnt = 0;
  logic [AW-1:0] m_ang;
  logic          m_tanh;

  // stand-in activation unit
  bit            u_pend;
  bit            u_have;
  int            u_cnt;
  int            fixed_lat;
  logic [AW-1:0] u_ang;
  logic          u_tanh;

  function automatic logic [DW-1:0] unit_fn(input logic [AW-1:0] a, input logic t);
    return {(t ? 11'h5A5 : 11'h0C3), a} ^ 32'h0000_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL timeout_%s: operation never completed at t=%0t", name, $time);
  endtask

  task automatic pack();
    req_v_i        = lane_v;
    req_tanh_sel_i = lane_tanh;
    for (int k = 0; k < N; k++) req_ang_i[k*AW +: AW] = lane_ang[k];
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (accepted[k]) begin
        accepted[k]  = 1'b0;
        lane_v[k]    = (mode == 2) ? 1'b1 : ((mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        lane_ang[k]  = AW'($urandom);
        lane_tanh[k] = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        lane_v[k] = 1'b1;
      end else if (!lane_v[k] && mode == 0) begin
        lane_v[k] = ($urandom_range(0, 3) == 0);
      end
    end
    pack();
    act_ready_i = !u_pend && ((mode != 0) || ($urandom_range(0, 1) == 1));
    act_v_i     = u_have || (!u_pend && mode == 0 && $urandom_range(0, 7) == 0);
    act_data_i  = u_have ? unit_fn(u_ang, u_tanh) : DW'($urandom);
    resp_yumi_i = (mode == 1) ? yumi_force : N'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_ops(input int n, input string name);
    int target;
    int t;
    target = done_cnt + n;
    t = 0;
    while (done_cnt < target && t < 200) begin
      step();
      t++;
    end
    if (done_cnt < target) timeout_fail(name);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},      64'(busy_o), 64'(0));
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'(0));
    chk({tag, "_resp_v"},    64'(resp_v_o), 64'(0));
    chk({tag, "_resp_data"}, 64'(resp_data_o), 64'(0));
    chk({tag, "_act_v"},     64'(act_v_o), 64'(0));
    chk({tag, "_act_ang"},   64'(act_ang_o), 64'(0));
    chk({tag, "_act_tanh"},  64'(act_tanh_sel_o), 64'(0));
    chk({tag, "_act_yumi"},  64'(act_yumi_o), 64'(0));
  endtask

  // Model: predicts grants from the driven request vector, pushes expected results, plays the unit
  always @(negedge clk) begin : sampler
    logic [N-1:0] exp_rdy;
    int           w;
    if (reset_i) begin
      m_busy      = 1'b0;
      m_last      = N - 1;
      busy_cycles = 0;
      exp_q.delete();
      done_seen   = done_cnt;
      accepted    = '0;
      u_pend      = 1'b0;
      u_have      = 1'b0;
      u_cnt       = 0;
    end else begin
      if (done_cnt != done_seen) begin
        done_seen = done_cnt;
        m_busy    = 1'b0;
      end
      chk("busy", 64'(busy_o), 64'(m_busy));
      exp_rdy = '0;
      w = -1;
      if (!m_busy) begin
        for (int i = 1; i <= N; i++) begin
          if (w < 0 && req_v_i[(m_last + i) % N]) w = (m_last + i) % N;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
      if (w >= 0) begin
        exp_t e;
        e.lane = w;
        e.data = unit_fn(req_ang_i[w*AW +: AW], req_tanh_sel_i[w]);
        exp_q.push_back(e);
        m_ang       = req_ang_i[w*AW +: AW];
        m_tanh      = req_tanh_sel_i[w];
        m_busy      = 1'b1;
        m_last      = w;
        accepted[w] = 1'b1;
        g_cnt++;
        busy_cycles = 0;
      end else if (m_busy) begin
        busy_cycles++;
        if (busy_cycles > 200) begin
          n_tests++;
          n_fail++;
          $display("FAIL watchdog: op outstanding for %0d cycles, required under 200", busy_cycles);
          $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
          $finish;
        end
      end
      if (u_pend) begin
        chk("act_v_after_issue", 64'(act_v_o), 64'(0));
        chk("act_ang_hold", 64'(act_ang_o), 64'(u_ang));
        chk("act_tanh_hold", 64'(act_tanh_sel_o), 64'(u_tanh));
        if (u_have && act_yumi_o) begin
          u_pend = 1'b0;
          u_have = 1'b0;
        end else if (!u_have) begin
          if (u_cnt == 0) u_have = 1'b1;
          else u_cnt--;
        end
      end else if (act_v_o && act_ready_i) begin
        chk("act_ang", 64'(act_ang_o), 64'(m_ang));
        chk("act_tanh", 64'(act_tanh_sel_o), 64'(m_tanh));
        u_pend = 1'b1;
        u_ang  = act_ang_o;
        u_tanh = act_tanh_sel_o;
        u_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
      end
    end
  end

  // Monitor: compares every presented result against the scoreboard head
  always begin : monitor
    exp_t         e;
    logic [N-1:0] onehot;
    @(negedge clk);
    #1;
    if (!reset_i) begin
      if (exp_q.size() == 0) begin
        chk("resp_v_idle", 64'(resp_v_o), 64'(0));
        chk("resp_data_idle", 64'(resp_data_o), 64'(0));
        chk("act_yumi_idle", 64'(act_yumi_o), 64'(0));
      end else if (resp_v_o != '0) begin
        e = exp_q[0];
        onehot = '0;
        onehot[e.lane] = 1'b1;
        chk("resp_v", 64'(resp_v_o), 64'(onehot));
        chk("resp_data", 64'(resp_data_o), 64'(e.data));
        chk("act_yumi", 64'(act_yumi_o), 64'(resp_yumi_i[e.lane]));
        if (resp_yumi_i[e.lane]) begin
          void'(exp_q.pop_front());
          done_cnt++;
        end
      end else begin
        chk("resp_data_zero", 64'(resp_data_o), 64'(0));
        chk("act_yumi_early", 64'(act_yumi_o), 64'(0));
      end
    end
  end

  initial begin
    int g0;
    int t;
    reset_i     = 1'b1;
    mode        = 1;
    yumi_force  = '0;
    fixed_lat   = -1;
    accepted    = '0;
    lane_tanh   = '0;
    for (int k = 0; k < N; k++) lane_ang[k] = AW'($urandom);
    act_ready_i = 1'b0;
    act_v_i     = 1'b0;
    act_data_i  = '0;
    resp_yumi_i = '1;
    lane_v      = '1;
    pack();
    repeat (2) @(posedge clk);
    #2;
    check_zero("reset");
    lane_v = '0;
    pack();
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // single requester, tanh(1.0)
    lane_v[1] = 1'b1; lane_ang[1] = 21'h10000; lane_tanh[1] = 1'b1;
    fixed_lat = 2; yumi_force = 4'b0010;
    wait_ops(1, "single");

    // owner 2 stalled in RESP while non-owner lanes assert yumi
    lane_v[2] = 1'b1; lane_ang[2] = 21'h0ABCD; lane_tanh[2] = 1'b0;
    yumi_force = 4'b1011;
    repeat (25) step();
    chk("stall_busy", 64'(busy_o), 64'(1));
    chk("stall_resp_v", 64'(resp_v_o), 64'(4'b0100));
    yumi_force = 4'b0100;
    wait_ops(1, "stall");

    // sigmoid(-8.0) on lane 0; lane input is re-randomised right after accept
    lane_v[0] = 1'b1; lane_ang[0] = 21'h180000; lane_tanh[0] = 1'b0;
    fixed_lat = 4; yumi_force = 4'b0001;
    wait_ops(1, "sigmoid");

    // asynchronous reset while waiting on the unit
    fixed_lat = 8; yumi_force = 4'b0010;
    lane_v[1] = 1'b1; lane_ang[1] = 21'h04321; lane_tanh[1] = 1'b1;
    g0 = g_cnt;
    t = 0;
    while (g_cnt == g0 && t < 20) begin
      step();
      t++;
    end
    if (g_cnt == g0) timeout_fail("grant_before_reset");
    repeat (3) step();
    chk("wait_busy", 64'(busy_o), 64'(1));
    chk("wait_act_v", 64'(act_v_o), 64'(0));
    mode = 2;
    lane_v = '1;
    pack();
    #2;
    reset_i = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (2) step();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    fixed_lat = -1;
    drive();

    // all lanes continuously valid: strict 0,1,2,3 rotation
    wait_ops(8, "all_valid");
    repeat (300) step();

    // fully random traffic, stray unit valids and random yumis
    mode = 0;
    repeat (3000) step();

    // drain
    mode = 1;
    yumi_force = '1;
    lane_v = '0;
    t = 0;
    while ((exp_q.size() != 0 || m_busy) && t < 200) begin
      step();
      t++;
    end
    if (exp_q.size() != 0 || m_busy) timeout_fail("drain");
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
